// File: rtl/vram_portb_pkg.sv
// Shared types for the VRAM port-B requester: RAM select, queued request record.
package vram_portb_pkg;

  localparam int NUM_VRAM    = 4;
  localparam int VRAM_ADDR_W = 12;
  localparam int VRAM_DATA_W = 64;
  localparam int VRAM_BE_W   = VRAM_DATA_W / 8;

  typedef enum logic [1:0] {
    SEL_TIL = 2'd0,
    SEL_PAT = 2'd1,
    SEL_PAL = 2'd2,
    SEL_SPR = 2'd3
  } vram_sel_e;

  typedef struct packed {
    logic                   wr;
    vram_sel_e              sel;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] wrdata;
    logic [VRAM_BE_W-1:0]   byteena;
  } vram_req_t;

  function automatic logic [NUM_VRAM-1:0] sel_onehot(input vram_sel_e sel);
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/vram_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit to tell full from empty.
module vram_req_fifo
  import vram_portb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  vram_req_t push_req,
  input  logic      pop,
  output vram_req_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  vram_req_t        mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_req;
  end

endmodule

// File: rtl/vram_portb_ctrl.sv
// VRAM port-B requester: queues CPU requests, issues them inside the PPU access window.
// Read path (response pipeline and q_b mux) is built only when VRAM_PORTB_RD_EN is defined.
module vram_portb_ctrl
  import vram_portb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr,
  input  logic [1:0]                   req_sel,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wrdata,
  input  logic [DATA_W/8-1:0]          req_byteena,
  input  logic                         win_open,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rddata,
  output logic [ADDR_W-1:0]            vram_addr_b,
  output logic [DATA_W-1:0]            vram_wrdata_b,
  output logic [DATA_W/8-1:0]          vram_byteena_b,
  output logic [NUM_VRAM-1:0]          vram_wren_b,
  input  logic [NUM_VRAM*DATA_W-1:0]   vram_rddata_b,
  output logic                         busy
);

  localparam int BE_W = DATA_W / 8;
`ifdef VRAM_PORTB_RD_EN
  localparam bit RD_PATH = 1'b1;
`else
  localparam bit RD_PATH = 1'b0;
`endif

  vram_req_t req_in;
  vram_req_t head;
  logic      full;
  logic      empty;
  logic      issue;

  always_comb begin
    req_in         = '0;
    req_in.wr      = req_wr;
    req_in.sel     = vram_sel_e'(req_sel);
    req_in.addr    = VRAM_ADDR_W'(req_addr);
    req_in.wrdata  = VRAM_DATA_W'(req_wrdata);
    req_in.byteena = VRAM_BE_W'(req_byteena);
  end

  vram_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (req_valid),
    .push_req (req_in),
    .pop      (issue),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign req_ready = !full;
  assign issue     = !empty && win_open;

  // Issue stage: port-B registers, RAM sees the access the cycle after dequeue
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_addr_b    <= '0;
      vram_wrdata_b  <= '0;
      vram_byteena_b <= '0;
      vram_wren_b    <= '0;
    end else begin
      vram_wren_b <= '0;
      if (issue && (head.wr || RD_PATH)) vram_addr_b <= ADDR_W'(head.addr);
      if (issue && head.wr) begin
        vram_wren_b    <= sel_onehot(head.sel);
        vram_wrdata_b  <= DATA_W'(head.wrdata);
        vram_byteena_b <= BE_W'(head.byteena);
      end
    end
  end

`ifdef VRAM_PORTB_RD_EN
  logic [RD_LAT:0]   vld_p;
  vram_sel_e         sel_p [RD_LAT+1];
  logic [DATA_W-1:0] rsp_mux;
  logic [DATA_W-1:0] rsp_hold;

  // Read pipeline: stage 0 aligns with the registered address, stage RD_LAT with q_b
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue && !head.wr;
      for (int i = 1; i <= RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    sel_p[0] <= head.sel;
    for (int i = 1; i <= RD_LAT; i++) sel_p[i] <= sel_p[i-1];
  end

  assign rsp_mux = vram_rddata_b[int'(sel_p[RD_LAT])*DATA_W +: DATA_W];

  // Response stage: hold the last returned word between pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_hold <= '0;
    end else if (vld_p[RD_LAT]) begin
      rsp_hold <= rsp_mux;
    end
  end

  assign rsp_valid  = vld_p[RD_LAT];
  assign rsp_rddata = rsp_valid ? rsp_mux : rsp_hold;
  assign busy       = !empty || (|vld_p);
`else
  logic unused_rd;
  assign unused_rd  = (^vram_rddata_b) ^ (RD_LAT > 0);
  assign rsp_valid  = 1'b0;
  assign rsp_rddata = '0;
  assign busy       = !empty;
`endif

endmodule

// File: tb/tb_vram_portb_ctrl.sv
// Directed bench for vram_portb_ctrl with a behavioural write-first 4-RAM port-B model.
module tb_vram_portb_ctrl;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 64;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LAT     = 2;
`ifdef VRAM_PORTB_RD_EN
  localparam bit RD = 1'b1;
`else
  localparam bit RD = 1'b0;
`endif

  logic                clk;
  logic                reset;
  logic                req_valid;
  logic                req_ready;
  logic                req_wr;
  logic [1:0]          req_sel;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wrdata;
  logic [DATA_W/8-1:0] req_byteena;
  logic                win_open;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rddata;
  logic [ADDR_W-1:0]   vram_addr_b;
  logic [DATA_W-1:0]   vram_wrdata_b;
  logic [DATA_W/8-1:0] vram_byteena_b;
  logic [3:0]          vram_wren_b;
  logic [4*DATA_W-1:0] vram_rddata_b;
  logic                busy;

  int total = 0;
  int bad   = 0;

  vram_portb_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_sel(req_sel), .req_addr(req_addr), .req_wrdata(req_wrdata),
    .req_byteena(req_byteena), .win_open(win_open), .rsp_valid(rsp_valid),
    .rsp_rddata(rsp_rddata), .vram_addr_b(vram_addr_b), .vram_wrdata_b(vram_wrdata_b),
    .vram_byteena_b(vram_byteena_b), .vram_wren_b(vram_wren_b),
    .vram_rddata_b(vram_rddata_b), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Untouched RAM words read back as a recognisable pattern: RAM index in the top byte
  function automatic logic [63:0] init_val(input int k, input logic [11:0] a);
    logic [7:0] tag;
    tag = 8'hA0 + 8'(k);
    return {tag, 40'h0, 4'h0, a};
  endfunction

  logic [63:0] mem [4][4096];
  logic        wrt [4][4096];
  logic [63:0] rd0 [4];
  logic [63:0] rd1 [4];
  logic [63:0] v;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++)
        for (int a = 0; a < 4096; a++) wrt[k][a] <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        v = wrt[k][vram_addr_b] ? mem[k][vram_addr_b] : init_val(k, vram_addr_b);
        if (vram_wren_b[k]) begin
          for (int b = 0; b < 8; b++)
            if (vram_byteena_b[b]) v[b*8 +: 8] = vram_wrdata_b[b*8 +: 8];
          mem[k][vram_addr_b] <= v;
          wrt[k][vram_addr_b] <= 1'b1;
        end
        rd0[k] <= v;
      end
    end
    for (int k = 0; k < 4; k++) rd1[k] <= rd0[k];
  end

  assign vram_rddata_b = {rd1[3], rd1[2], rd1[1], rd1[0]};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic wr, input logic [1:0] sel, input logic [11:0] addr,
                         input logic [63:0] data, input logic [7:0] be);
    req_valid   = 1'b1;
    req_wr      = wr;
    req_sel     = sel;
    req_addr    = addr;
    req_wrdata  = data;
    req_byteena = be;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [11:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [3:0]  exp_wren;
  } wvec_t;

  wvec_t       wv [4];
  logic [63:0] exp_d;

  initial begin
    wv[0] = '{2'd0, 12'h010, 64'h1122334455667788, 8'hFF, 4'b0001};
    wv[1] = '{2'd1, 12'h7FF, 64'h0F0E0D0C0B0A0908, 8'hA5, 4'b0010};
    wv[2] = '{2'd2, 12'h003, 64'hCAFEBABEDEADBEEF, 8'h0F, 4'b0100};
    wv[3] = '{2'd3, 12'hFFF, 64'h00000000000000C3, 8'h01, 4'b1000};

    reset = 1'b1; win_open = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_sel = 2'd0;
    req_addr = '0; req_wrdata = '0; req_byteena = '0;
    step(); step();
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_rddata, 64'h0);
    chk("rst_wren", vram_wren_b, 4'b0000);
    chk("rst_addr", vram_addr_b, 12'h000);
    chk("rst_wrdata", vram_wrdata_b, 64'h0);
    chk("rst_byteena", vram_byteena_b, 8'h00);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    step();

    // Single writes: wren one-hot two cycles after the request is presented
    win_open = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, wv[i].sel, wv[i].addr, wv[i].data, wv[i].be);
      step();
      req_valid = 1'b0;
      chk("wr_queued_wren", vram_wren_b, 4'b0000);
      chk("wr_queued_busy", busy, 1'b1);
      step();
      chk("wr_wren", vram_wren_b, wv[i].exp_wren);
      chk("wr_addr", vram_addr_b, wv[i].addr);
      chk("wr_data", vram_wrdata_b, wv[i].data);
      chk("wr_be", vram_byteena_b, wv[i].be);
      chk("wr_idle_busy", busy, 1'b0);
      step();
      chk("wr_pulse_end", vram_wren_b, 4'b0000);
      chk("wr_addr_hold", vram_addr_b, wv[i].addr);
    end

    // Partial write to palette 0x003 followed by a read of the same word
    set_req(1'b1, 2'd2, 12'h003, 64'h0123456789ABCDEF, 8'h0F);
    step();
    set_req(1'b0, 2'd2, 12'h003, 64'h0, 8'h00);
    step();
    req_valid = 1'b0;
    chk("raw_wr_wren", vram_wren_b, 4'b0100);
    step();
    chk("raw_rd_wren", vram_wren_b, 4'b0000);
    chk("raw_rd_addr", vram_addr_b, 12'h003);
    chk("raw_rd_be_hold", vram_byteena_b, 8'h0F);
    for (int c = 3; c <= 7; c++) begin
      chk("raw_rsp_valid", rsp_valid, RD && (c == 5));
      chk("raw_rsp_data", rsp_rddata, (RD && c >= 5) ? 64'hA2000000_89ABCDEF : 64'h0);
      if (c == 4) chk("raw_busy_inflight", busy, RD);
      step();
    end
    chk("raw_busy_done", busy, 1'b0);

    // Read then write: the write follows the read by exactly one issue slot
    set_req(1'b0, 2'd0, 12'h005, 64'h0, 8'h00);
    step();
    set_req(1'b1, 2'd0, 12'h006, 64'h5555AAAA5555AAAA, 8'hFF);
    step();
    req_valid = 1'b0;
    chk("rw_rd_wren", vram_wren_b, 4'b0000);
    chk("rw_rd_addr", vram_addr_b, RD ? 12'h005 : 12'h003);
    step();
    chk("rw_wr_wren", vram_wren_b, 4'b0001);
    chk("rw_wr_addr", vram_addr_b, 12'h006);
    chk("rw_rsp_early", rsp_valid, 1'b0);
    step();
    chk("rw_rsp_valid", rsp_valid, RD);
    chk("rw_rsp_data", rsp_rddata, RD ? 64'hA0000000_00000005 : 64'h0);
    step();
    chk("rw_rsp_once", rsp_valid, 1'b0);
    chk("rw_rsp_hold", rsp_rddata, RD ? 64'hA0000000_00000005 : 64'h0);
    step(); step();

    // Window closed: four writes fill the FIFO, the fifth is refused
    win_open = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("full_ready", req_ready, i < 4);
      chk("full_no_wren", vram_wren_b, 4'b0000);
      set_req(1'b1, 2'd3, 12'h020 + 12'(i), 64'h00F0 + 64'(i), 8'hFF);
      step();
    end
    req_valid = 1'b0;
    chk("full_ready_held", req_ready, 1'b0);
    chk("full_busy", busy, 1'b1);
    chk("full_no_wren2", vram_wren_b, 4'b0000);
    win_open = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("drain_wren", vram_wren_b, 4'b1000);
      chk("drain_addr", vram_addr_b, 12'h020 + 12'(i));
      chk("drain_data", vram_wrdata_b, 64'h00F0 + 64'(i));
      chk("drain_ready", req_ready, 1'b1);
      step();
    end
    chk("drain_end_wren", vram_wren_b, 4'b0000);
    chk("drain_end_busy", busy, 1'b0);

    // Back-to-back sprite reads 0..3: one response per cycle, in order
    for (int c = 0; c < 10; c++) begin
      if (!RD)         exp_d = 64'h0;
      else if (c < 4)  exp_d = 64'hA0000000_00000005;
      else if (c <= 7) exp_d = init_val(3, 12'(c - 4));
      else             exp_d = init_val(3, 12'h003);
      chk("b2b_rsp_valid", rsp_valid, RD && (c >= 4) && (c <= 7));
      chk("b2b_rsp_data", rsp_rddata, exp_d);
      chk("b2b_wren", vram_wren_b, 4'b0000);
      if (c < 4) set_req(1'b0, 2'd3, 12'(c), 64'h0, 8'h00);
      else       req_valid = 1'b0;
      step();
    end

    // Reset with two reads in flight and two still queued
    win_open = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b0, 2'd0, 12'(i), 64'h0, 8'h00);
      step();
    end
    req_valid = 1'b0;
    chk("mid_full", req_ready, 1'b0);
    win_open = 1'b1;
    step(); step();
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_rsp_data", rsp_rddata, 64'h0);
    chk("mid_rst_wren", vram_wren_b, 4'b0000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("post_rst_rsp", rsp_valid, 1'b0);
      chk("post_rst_wren", vram_wren_b, 4'b0000);
      chk("post_rst_busy", busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
